// File: rtl/text_console_pkg.sv
// Shared constants and state encoding for the text console writer.
package text_console_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  localparam logic [7:0] BLANK = 8'h20;

  // Control codes recognised by the writer
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // Pre-sized cursor and address constants so comparisons stay width-exact
  localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
  localparam logic [10:0] ROW_STRIDE    = 11'(COLS);
  localparam logic [10:0] NUM_CELLS     = 11'(COLS * ROWS);
  localparam logic [10:0] LAST_ROW_BASE = 11'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {
    ST_CLEAR     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SCR_GAP   = 3'd2,
    ST_SCR_RD    = 3'd3,
    ST_SCR_WR    = 3'd4,
    ST_SCR_BLANK = 3'd5
  } state_t;

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream to character-RAM writer: cursor tracking, wrap, control codes,
// scroll-up by copying rows through port B, and clear-screen.
module text_console_writer
  import text_console_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [10:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  state_t      state_reg, state_next;
  logic [6:0]  col_reg, col_next;
  logic [4:0]  row_reg, row_next;
  // Linear cell index of the cursor, kept in step with col/row so that no
  // multiply is needed to form a write address.
  logic [10:0] cell_reg, cell_next;
  // Sweep index: clear address, scroll destination, or blank-row address.
  logic [10:0] scan_reg, scan_next;
  logic [10:0] addr_reg, addr_next;
  logic        we_reg, we_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        accept;
  logic        wraps_at_bottom;

  assign accept = ch_valid && (state_reg == ST_IDLE);

  // A byte that moves the cursor past the last row triggers a scroll
  assign wraps_at_bottom = (row_reg == LAST_ROW) &&
                           ((ch_data == CH_LF) ||
                            ((ch_data >= BLANK) && (col_reg == LAST_COL)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (scan_reg == NUM_CELLS) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept) begin
          if (ch_data == CH_FF) state_next = ST_CLEAR;
          else if (wraps_at_bottom) state_next = ST_SCR_GAP;
        end
      end
      ST_SCR_GAP: state_next = ST_SCR_RD;
      ST_SCR_RD:  state_next = ST_SCR_WR;
      ST_SCR_WR: begin
        if (scan_reg == LAST_ROW_BASE - 11'd1) state_next = ST_SCR_BLANK;
        else state_next = ST_SCR_RD;
      end
      ST_SCR_BLANK: begin
        if (scan_reg == NUM_CELLS) state_next = ST_IDLE;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  // Next values for cursor, sweep index and the registered port-B signals
  always_comb begin
    col_next   = col_reg;
    row_next   = row_reg;
    cell_next  = cell_reg;
    scan_next  = scan_reg;
    addr_next  = addr_reg;
    we_next    = 1'b0;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (scan_reg != NUM_CELLS) begin
          addr_next  = scan_reg;
          we_next    = 1'b1;
          wdata_next = BLANK;
          scan_next  = scan_reg + 11'd1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (ch_data >= BLANK) begin
            addr_next  = cell_reg;
            we_next    = 1'b1;
            wdata_next = ch_data;
            if (col_reg == LAST_COL) begin
              col_next = 7'd0;
              if (row_reg == LAST_ROW) begin
                cell_next = LAST_ROW_BASE;
              end else begin
                row_next  = row_reg + 5'd1;
                cell_next = cell_reg + 11'd1;
              end
            end else begin
              col_next  = col_reg + 7'd1;
              cell_next = cell_reg + 11'd1;
            end
          end else begin
            case (ch_data)
              CH_CR: begin
                col_next  = 7'd0;
                cell_next = cell_reg - {4'd0, col_reg};
              end
              CH_LF: begin
                col_next = 7'd0;
                if (row_reg == LAST_ROW) begin
                  cell_next = LAST_ROW_BASE;
                end else begin
                  row_next  = row_reg + 5'd1;
                  cell_next = cell_reg - {4'd0, col_reg} + ROW_STRIDE;
                end
              end
              CH_BS: begin
                if (col_reg != 7'd0) begin
                  col_next   = col_reg - 7'd1;
                  cell_next  = cell_reg - 11'd1;
                  addr_next  = cell_reg - 11'd1;
                  we_next    = 1'b1;
                  wdata_next = BLANK;
                end
              end
              CH_FF: begin
                // First clear write is issued now; the sweep resumes at 1
                col_next   = 7'd0;
                row_next   = 5'd0;
                cell_next  = 11'd0;
                addr_next  = 11'd0;
                we_next    = 1'b1;
                wdata_next = BLANK;
                scan_next  = 11'd1;
              end
              default: ;
            endcase
          end
        end
      end
      ST_SCR_GAP: begin
        // Read the source cell of the first copy (destination 0)
        addr_next = ROW_STRIDE;
        scan_next = 11'd0;
      end
      ST_SCR_RD: begin
        addr_next = scan_reg;
        we_next   = 1'b1;
      end
      ST_SCR_WR: begin
        if (scan_reg == LAST_ROW_BASE - 11'd1) begin
          addr_next  = LAST_ROW_BASE;
          we_next    = 1'b1;
          wdata_next = BLANK;
          scan_next  = LAST_ROW_BASE + 11'd1;
        end else begin
          addr_next = scan_reg + 11'd1 + ROW_STRIDE;
          scan_next = scan_reg + 11'd1;
        end
      end
      ST_SCR_BLANK: begin
        if (scan_reg != NUM_CELLS) begin
          addr_next  = scan_reg;
          we_next    = 1'b1;
          wdata_next = BLANK;
          scan_next  = scan_reg + 11'd1;
        end
      end
      default: ;
    endcase
  end

  // Cursor, sweep index and registered port-B outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg   <= 7'd0;
      row_reg   <= 5'd0;
      cell_reg  <= 11'd0;
      scan_reg  <= 11'd0;
      addr_reg  <= 11'd0;
      we_reg    <= 1'b0;
      wdata_reg <= BLANK;
    end else begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      cell_reg  <= cell_next;
      scan_reg  <= scan_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
    end
  end

  assign ch_ready   = (state_reg == ST_IDLE);
  assign busy       = (state_reg != ST_IDLE);
  assign ram_addr   = addr_reg;
  assign ram_we     = we_reg;
  // During the copy write the read data goes straight back out unregistered
  assign ram_wdata  = (state_reg == ST_SCR_WR) ? ram_rdata : wdata_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a behavioural screen model
// (plain array plus cursor) is compared against a port-B RAM model.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = 8'h00;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  text_console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // Port-B RAM with registered read (read-before-write) and a cycle counter
  logic [7:0] mem [0:2047];
  int cyc = 0;
  int wr_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_count <= wr_count + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference screen model
  logic [7:0] m_scr [0:1999];
  int mcol, mrow;
  int m_we, m_addr, m_data, m_busy;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_blank();
    for (int k = 0; k < 2000; k++) m_scr[k] = 8'h20;
  endtask

  task automatic model_scroll();
    for (int k = 0; k < 1920; k++) m_scr[k] = m_scr[k + 80];
    for (int k = 1920; k < 2000; k++) m_scr[k] = 8'h20;
    m_busy = 3921;
  endtask

  // Apply one byte to the model; record the expected write and busy length
  task automatic model_apply(input logic [7:0] b);
    m_we = 0; m_addr = 0; m_data = 0; m_busy = 0;
    if (b >= 8'h20) begin
      m_we = 1; m_addr = mrow * 80 + mcol; m_data = int'(b);
      m_scr[m_addr] = b;
      if (mcol == 79) begin
        mcol = 0;
        if (mrow == 24) model_scroll();
        else mrow++;
      end else begin
        mcol++;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      if (mrow == 24) model_scroll();
      else mrow++;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        m_we = 1; m_addr = mrow * 80 + mcol; m_data = 32'h20;
        m_scr[m_addr] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      mcol = 0; mrow = 0;
      model_blank();
      m_we = 1; m_addr = 0; m_data = 32'h20;
      m_busy = 2000;
    end
  endtask

  // Offer a byte (called at a negedge); returns at the negedge after acceptance
  task automatic send(input logic [7:0] b, output int acc_cyc);
    int guard;
    guard = 0;
    ch_data = b;
    ch_valid = 1'b1;
    while (ch_ready !== 1'b1 && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (ch_ready !== 1'b1) begin
      check("accept_timeout", 0, 1);
      ch_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ch_ready !== 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_screen(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 2000; k++) begin
      if (mem[k] !== m_scr[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    if (bad != 0)
      $display("screen %s: first differing cell %0d ram %02h model %02h",
               tag, first, mem[first], m_scr[first]);
    check(tag, bad, 0);
  endtask

  // One full transaction: model, send, compare write/cursor, wait if busy
  task automatic do_byte(input logic [7:0] b);
    int acc;
    int n;
    model_apply(b);
    send(b, acc);
    check("cursor_col", int'(cursor_col), mcol);
    check("cursor_row", int'(cursor_row), mrow);
    check("write_en", int'(ram_we), m_we);
    if (m_we != 0) begin
      check("write_addr", int'(ram_addr), m_addr);
      check("write_data", int'(ram_wdata), m_data);
    end
    $display("byte %02h at cycle %0d -> cursor (%0d,%0d) we=%0d addr=%0d data=%02h",
             b, acc, cursor_row, cursor_col, ram_we, ram_addr, ram_wdata);
    if (m_busy != 0) begin
      wait_idle(n);
      check("busy_cycles", n, m_busy);
    end else begin
      check("ready_after", int'(ch_ready), 1);
    end
  endtask

  initial begin
    int n;
    int w0;
    int acc1;
    int acc2;
    int r;
    logic [7:0] b;

    mcol = 0; mrow = 0;
    model_blank();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ch_ready", int'(ch_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_wdata", int'(ram_wdata), 32'h20);
    check("rst_cursor_col", int'(cursor_col), 0);
    check("rst_cursor_row", int'(cursor_row), 0);

    // Release: 2000 blank writes, ready from cycle 2001
    w0 = wr_count;
    rst_n = 1'b1;
    wait_idle(n);
    check("reset_clear_cycles", n, 2001);
    check("reset_clear_writes", wr_count - w0, 2000);
    check_screen("screen_after_reset");
    $display("reset release -> ready after %0d cycles, %0d writes", n, wr_count - w0);

    // Character, CR, LF, character
    do_byte(8'h41);
    check("a_addr", int'(ram_addr), 0);
    do_byte(8'h0D);
    do_byte(8'h0A);
    do_byte(8'h42);
    check("b_addr", int'(ram_addr), 80);
    check("b_cursor_row", int'(cursor_row), 1);
    check("b_cursor_col", int'(cursor_col), 1);

    // Backspace at (3,5) then at column 0
    do_byte(8'h0A);
    do_byte(8'h0A);
    for (int i = 0; i < 5; i++) do_byte(8'h61 + 8'(i));
    do_byte(8'h08);
    check("bs_addr", int'(ram_addr), 244);
    check("bs_data", int'(ram_wdata), 32'h20);
    do_byte(8'h0D);
    do_byte(8'h08);
    check("bs_col0_no_write", int'(ram_we), 0);
    check_screen("screen_after_bs");

    // Fill to (24,79) and wrap into a scroll
    for (int i = 0; i < 21; i++) do_byte(8'h0A);
    for (int i = 0; i < 79; i++) do_byte(8'h30 + 8'(i % 40));
    do_byte(8'h5A);
    check_screen("screen_after_scroll");

    // Form feed with the next byte offered throughout the clear
    model_apply(8'h0C);
    send(8'h0C, acc1);
    check("ff_cursor_col", int'(cursor_col), 0);
    check("ff_cursor_row", int'(cursor_row), 0);
    check("ff_first_write", int'(ram_we), 1);
    $display("byte 0c at cycle %0d -> clear started", acc1);
    model_apply(8'h51);
    send(8'h51, acc2);
    check("ff_hold_latency", acc2 - acc1, 2001);
    check("ff_next_addr", int'(ram_addr), 0);
    check("ff_next_data", int'(ram_wdata), 32'h51);
    check("ff_next_col", int'(cursor_col), 1);
    $display("byte 51 at cycle %0d -> cursor (%0d,%0d) addr=%0d", acc2, cursor_row, cursor_col, ram_addr);
    @(negedge clk);
    check_screen("screen_after_ff");

    // Randomised byte stream against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) b = 8'($urandom_range(32, 255));
      else if (r < 78) b = 8'h0D;
      else if (r < 87) b = 8'h0A;
      else if (r < 95) b = 8'h08;
      else if (r < 99) begin
        b = 8'($urandom_range(0, 31));
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h1B;
      end else b = 8'h0C;
      do_byte(b);
      if (i % 50 == 49) begin
        @(negedge clk);
        check_screen("screen_random");
      end
    end

    // Asynchronous reset in the middle of a scroll
    do_byte(8'h0C);
    for (int i = 0; i < 24; i++) do_byte(8'h0A);
    send(8'h0A, acc1);
    $display("byte 0a at cycle %0d -> scroll started, reset follows", acc1);
    repeat (100) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ram_we", int'(ram_we), 0);
    check("midrst_ch_ready", int'(ch_ready), 0);
    check("midrst_busy", int'(busy), 1);
    check("midrst_cursor_col", int'(cursor_col), 0);
    check("midrst_cursor_row", int'(cursor_row), 0);
    mcol = 0; mrow = 0;
    model_blank();
    @(negedge clk);
    w0 = wr_count;
    rst_n = 1'b1;
    wait_idle(n);
    check("midrst_clear_cycles", n, 2001);
    check("midrst_clear_writes", wr_count - w0, 2000);
    check_screen("screen_after_midrst");
    do_byte(8'h7E);
    $display("reset mid-scroll -> ready after %0d cycles", n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
